execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/exec_pkg.sv | 26 ++
 rtl/execute_stage_alu.sv | 66 ++++++
 rtl/execute_stage.sv | 166 ++++++++++++++++
 tb/tb_execute_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcode encoding, status flag layout,
// skid-buffer occupancy states and the default datapath width.
package exec_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MOV = 2'b11
  } opcode_e;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
  } nvz_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } buf_state_e;

endpackage

// File: rtl/execute_stage_alu.sv
// Saturating signed integer ALU for add, sub and mul; overflow clamps the
// result to the nearest representable extreme and raises overflow_o.
module ALU_Integer
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  opcode_e               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  overflow_o
);

  localparam logic [DATA_WIDTH-1:0] MaxPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0]     sumExt;
  logic [DATA_WIDTH:0]     diffExt;
  logic [2*DATA_WIDTH-1:0] prodExt;
  logic [DATA_WIDTH:0]     prodTop;

  // One guard bit is enough for add/sub; the product needs full double width.
  assign sumExt  = $signed({a_i[DATA_WIDTH-1], a_i}) + $signed({b_i[DATA_WIDTH-1], b_i});
  assign diffExt = $signed({a_i[DATA_WIDTH-1], a_i}) - $signed({b_i[DATA_WIDTH-1], b_i});
  assign prodExt = $signed({{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i})
                 * $signed({{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i});
  assign prodTop = prodExt[2*DATA_WIDTH-1:DATA_WIDTH-1];

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        if (sumExt[DATA_WIDTH] != sumExt[DATA_WIDTH-1]) begin
          overflow_o = 1'b1;
          result_o   = sumExt[DATA_WIDTH] ? MinNeg : MaxPos;
        end else begin
          result_o = sumExt[DATA_WIDTH-1:0];
        end
      end
      OP_SUB: begin
        if (diffExt[DATA_WIDTH] != diffExt[DATA_WIDTH-1]) begin
          overflow_o = 1'b1;
          result_o   = diffExt[DATA_WIDTH] ? MinNeg : MaxPos;
        end else begin
          result_o = diffExt[DATA_WIDTH-1:0];
        end
      end
      OP_MUL: begin
        // The product fits only if every bit above the result's sign bit matches it.
        if ((|prodTop) && !(&prodTop)) begin
          overflow_o = 1'b1;
          result_o   = prodExt[2*DATA_WIDTH-1] ? MinNeg : MaxPos;
        end else begin
          result_o = prodExt[DATA_WIDTH-1:0];
        end
      end
      default: begin
        result_o   = '0;
        overflow_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: one-cycle saturating ALU with a main output register plus a
// skid register, valid/ready handshakes on both sides and a status register.
module execute_stage
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_opcode,
  input  logic [DATA_WIDTH-1:0]     in_a,
  input  logic [DATA_WIDTH-1:0]     in_b,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_setflags,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [2:0]                out_nvz,
  output logic [2:0]                status_nvz
);

  opcode_e                   opcode;
  logic [DATA_WIDTH-1:0]     aluResult;
  logic                      aluOverflow;
  logic [DATA_WIDTH-1:0]     opResult;
  nvz_t                      opFlags;

  buf_state_e                state_q, state_d;
  logic                      inReady_q, inReady_d;
  logic                      accept, drain;
  logic                      loadMain, loadSkid, skidToMain;

  logic [DATA_WIDTH-1:0]     mainResult_q, mainResult_d;
  logic [REG_ADDR_WIDTH-1:0] mainRd_q, mainRd_d;
  nvz_t                      mainNvz_q, mainNvz_d;
  logic [DATA_WIDTH-1:0]     skidResult_q, skidResult_d;
  logic [REG_ADDR_WIDTH-1:0] skidRd_q, skidRd_d;
  nvz_t                      skidNvz_q, skidNvz_d;
  nvz_t                      statusNvz_q, statusNvz_d;

  assign opcode = opcode_e'(in_opcode);

  ALU_Integer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op_i      (opcode),
    .a_i       (in_a),
    .b_i       (in_b),
    .result_o  (aluResult),
    .overflow_o(aluOverflow)
  );

  // Move bypasses the ALU; flags are derived from whichever result is selected.
  always_comb begin
    opResult  = (opcode == OP_MOV) ? in_b : aluResult;
    opFlags   = '0;
    opFlags.n = opResult[DATA_WIDTH-1];
    opFlags.v = (opcode != OP_MOV) && aluOverflow;
    opFlags.z = (opResult == '0);
  end

  assign accept = in_valid && inReady_q;
  assign drain  = (state_q != ST_EMPTY) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      inReady_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inReady_q <= inReady_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !drain)      state_d = ST_FULL;
        else if (!accept && drain) state_d = ST_EMPTY;
      end
      ST_FULL:  if (drain) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    // Ready is registered, so it is computed from the state being entered.
    inReady_d = (state_d != ST_FULL);
  end

  always_comb begin
    loadMain   = 1'b0;
    loadSkid   = 1'b0;
    skidToMain = 1'b0;
    case (state_q)
      ST_EMPTY: loadMain = accept;
      ST_ONE: begin
        loadMain = accept && drain;
        loadSkid = accept && !drain;
      end
      ST_FULL:  skidToMain = drain;
      default: begin
        loadMain   = 1'b0;
        loadSkid   = 1'b0;
        skidToMain = 1'b0;
      end
    endcase
  end

  always_comb begin
    mainResult_d = mainResult_q;
    mainRd_d     = mainRd_q;
    mainNvz_d    = mainNvz_q;
    skidResult_d = skidResult_q;
    skidRd_d     = skidRd_q;
    skidNvz_d    = skidNvz_q;
    if (loadMain) begin
      mainResult_d = opResult;
      mainRd_d     = in_rd;
      mainNvz_d    = opFlags;
    end else if (skidToMain) begin
      mainResult_d = skidResult_q;
      mainRd_d     = skidRd_q;
      mainNvz_d    = skidNvz_q;
    end
    if (loadSkid) begin
      skidResult_d = opResult;
      skidRd_d     = in_rd;
      skidNvz_d    = opFlags;
    end
  end

  // Status follows the accept edge, not writeback, so backpressure cannot delay it.
  assign statusNvz_d = (accept && in_setflags) ? opFlags : statusNvz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainResult_q <= '0;
      mainRd_q     <= '0;
      mainNvz_q    <= '0;
      skidResult_q <= '0;
      skidRd_q     <= '0;
      skidNvz_q    <= '0;
      statusNvz_q  <= '0;
    end else begin
      mainResult_q <= mainResult_d;
      mainRd_q     <= mainRd_d;
      mainNvz_q    <= mainNvz_d;
      skidResult_q <= skidResult_d;
      skidRd_q     <= skidRd_d;
      skidNvz_q    <= skidNvz_d;
      statusNvz_q  <= statusNvz_d;
    end
  end

  assign in_ready   = inReady_q;
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_result = mainResult_q;
  assign out_rd     = mainRd_q;
  assign out_nvz    = mainNvz_q;
  assign status_nvz = statusNvz_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: a vector table plus hand-written
// backpressure and reset sequences, with a queue scoreboard on the output side.
module tb_execute_stage;
  import exec_pkg::*;

  localparam int W  = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [1:0]    in_opcode;
  logic [W-1:0]  in_a, in_b;
  logic [RW-1:0] in_rd;
  logic          in_setflags;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic [RW-1:0] out_rd;
  logic [2:0]    out_nvz, status_nvz;

  always #5 clk = ~clk;

  execute_stage #(
    .DATA_WIDTH(W),
    .REG_ADDR_WIDTH(RW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .in_setflags(in_setflags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_nvz    (out_nvz),
    .status_nvz (status_nvz)
  );

  typedef struct {
    logic [W-1:0]  result;
    logic [RW-1:0] rd;
    logic [2:0]    nvz;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sf;
    logic [W-1:0]  expResult;
    logic [2:0]    expNvz;
  } vec_t;

  exp_t         sbQ[$];
  vec_t         vecs[14];
  int           checks = 0;
  int           errors = 0;
  int           cycleCnt = 0;
  int           popCnt = 0;
  logic [W-1:0] curExpResult;
  logic [2:0]   curExpNvz;
  logic [2:0]   expStatus = 3'b000;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Independent reference: exact integer result, then clamp to the 8-bit range.
  task automatic modelOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [2:0] nvz);
    int sa, sb, full;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'b00:   full = sa + sb;
      2'b01:   full = sa - sb;
      2'b10:   full = sa * sb;
      default: full = sb;
    endcase
    v = 1'b0;
    if (full > 127) begin
      r = 8'h7F;
      v = 1'b1;
    end else if (full < -128) begin
      r = 8'h80;
      v = 1'b1;
    end else begin
      r = full[7:0];
    end
    nvz = {r[7], v, (r == 8'h00)};
  endtask

  // Scoreboard: pop and compare on output transfer, push on input accept.
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    if (!rst_n) begin
      sbQ.delete();
      expStatus = 3'b000;
    end else begin
      checkOutput("status_nvz", {29'd0, status_nvz}, {29'd0, expStatus});
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got 0x%0h expected none at %0t", out_result, $time);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sb_result", {24'd0, out_result}, {24'd0, e.result});
          checkOutput("sb_rd", {28'd0, out_rd}, {28'd0, e.rd});
          checkOutput("sb_nvz", {29'd0, out_nvz}, {29'd0, e.nvz});
          popCnt++;
        end
      end
      if (in_valid && in_ready) begin
        n.result = curExpResult;
        n.rd     = in_rd;
        n.nvz    = curExpNvz;
        sbQ.push_back(n);
        if (in_setflags) expStatus = curExpNvz;
      end
    end
  end

  task automatic driveOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RW-1:0] rd, input logic sf,
                         input logic [W-1:0] expR, input logic [2:0] expNvz);
    in_valid     = 1'b1;
    in_opcode    = op;
    in_a         = a;
    in_b         = b;
    in_rd        = rd;
    in_setflags  = sf;
    curExpResult = expR;
    curExpNvz    = expNvz;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic waitAccept();
    logic accepted;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("accept_timeout", {31'd0, accepted}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [RW-1:0] rd, input logic sf,
                               input logic [W-1:0] expR, input logic [2:0] expNvz);
    driveOp(op, a, b, rd, sf, expR, expNvz);
    waitAccept();
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb, rr;
    logic [1:0]   rop;
    logic [2:0]   rnvz;
    int           startCycle, startPop;

    vecs[0]  = '{2'b00, 8'h7F, 8'h01, 1'b1, 8'h7F, 3'b010};
    vecs[1]  = '{2'b10, 8'hC0, 8'h0A, 1'b1, 8'h80, 3'b110};
    vecs[2]  = '{2'b11, 8'h12, 8'h80, 1'b0, 8'h80, 3'b100};
    vecs[3]  = '{2'b01, 8'h80, 8'h01, 1'b1, 8'h80, 3'b110};
    vecs[4]  = '{2'b01, 8'h05, 8'h07, 1'b0, 8'hFE, 3'b100};
    vecs[5]  = '{2'b00, 8'h80, 8'h80, 1'b1, 8'h80, 3'b110};
    vecs[6]  = '{2'b10, 8'h10, 8'h08, 1'b0, 8'h7F, 3'b010};
    vecs[7]  = '{2'b10, 8'hFF, 8'hFF, 1'b1, 8'h01, 3'b000};
    vecs[8]  = '{2'b01, 8'h04, 8'h04, 1'b1, 8'h00, 3'b001};
    vecs[9]  = '{2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 3'b001};
    vecs[10] = '{2'b11, 8'h7F, 8'h00, 1'b1, 8'h00, 3'b001};
    vecs[11] = '{2'b10, 8'hF0, 8'h08, 1'b1, 8'h80, 3'b100};
    vecs[12] = '{2'b00, 8'h40, 8'h3F, 1'b0, 8'h7F, 3'b000};
    vecs[13] = '{2'b01, 8'h7F, 8'h80, 1'b1, 8'h7F, 3'b010};

    rst_n = 1'b0;
    in_valid = 1'b0; in_opcode = 2'b00; in_a = '0; in_b = '0; in_rd = '0; in_setflags = 1'b0;
    out_ready = 1'b0;
    curExpResult = '0; curExpNvz = '0;

    #2;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_result", {24'd0, out_result}, 32'd0);
    checkOutput("rst_out_rd", {28'd0, out_rd}, 32'd0);
    checkOutput("rst_out_nvz", {29'd0, out_nvz}, 32'd0);
    checkOutput("rst_status", {29'd0, status_nvz}, 32'd0);

    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    checkOutput("ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_after_reset", {31'd0, in_ready}, 32'd1);

    $display("[TB] basic add with flags");
    out_ready = 1'b1;
    applyStimulus(2'b00, 8'h01, 8'h01, 4'd3, 1'b1, 8'h02, 3'b000);
    in_valid = 1'b0;
    checkOutput("add_latency_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("add_result", {24'd0, out_result}, 32'h02);
    checkOutput("add_nvz", {29'd0, out_nvz}, 32'd0);
    checkOutput("add_status", {29'd0, status_nvz}, 32'd0);
    idle(2);

    $display("[TB] vector table, back-to-back");
    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, RW'(i), vecs[i].sf,
                    vecs[i].expResult, vecs[i].expNvz);
    idle(3);
    checkOutput("table_drained", sbQ.size(), 32'd0);

    $display("[TB] sub without setflags keeps status");
    applyStimulus(2'b01, 8'h05, 8'h07, 4'd4, 1'b1, 8'hFE, 3'b100);
    applyStimulus(2'b01, 8'h04, 8'h04, 4'd5, 1'b0, 8'h00, 3'b001);
    in_valid = 1'b0;
    checkOutput("sub_zero_nvz", {29'd0, out_nvz}, 32'b001);
    checkOutput("sub_status_kept", {29'd0, status_nvz}, 32'b100);
    idle(2);

    $display("[TB] backpressure with three ops");
    out_ready = 1'b0;
    driveOp(2'b00, 8'h10, 8'h20, 4'd1, 1'b0, 8'h30, 3'b000);
    @(posedge clk); #1;
    driveOp(2'b01, 8'h10, 8'h20, 4'd2, 1'b0, 8'hF0, 3'b100);
    @(posedge clk); #1;
    driveOp(2'b10, 8'h03, 8'h05, 4'd3, 1'b1, 8'h0F, 3'b000);
    checkOutput("bp_ready_low", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("bp_first_result", {24'd0, out_result}, 32'h30);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_hold_result", {24'd0, out_result}, 32'h30);
    checkOutput("bp_hold_rd", {28'd0, out_rd}, 32'd1);
    checkOutput("bp_hold_status", {29'd0, status_nvz}, 32'b100);
    out_ready = 1'b1;
    waitAccept();
    idle(3);
    checkOutput("bp_drained", sbQ.size(), 32'd0);

    $display("[TB] reset while full");
    out_ready = 1'b0;
    applyStimulus(2'b00, 8'h7F, 8'h7F, 4'd6, 1'b1, 8'h7F, 3'b010);
    applyStimulus(2'b01, 8'h00, 8'h01, 4'd7, 1'b1, 8'hFF, 3'b100);
    in_valid = 1'b0;
    checkOutput("full_ready_low", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_status", {29'd0, status_nvz}, 32'd0);
    checkOutput("midrst_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("midrst_result", {24'd0, out_result}, 32'd0);
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postrst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    applyStimulus(2'b00, 8'h05, 8'h03, 4'd7, 1'b1, 8'h08, 3'b000);
    in_valid = 1'b0;
    checkOutput("postrst_latency", {31'd0, out_valid}, 32'd1);
    checkOutput("postrst_result", {24'd0, out_result}, 32'h08);
    idle(2);

    $display("[TB] sixteen back-to-back ops");
    startCycle = cycleCnt;
    startPop   = popCnt;
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      modelOp(rop, ra, rb, rr, rnvz);
      applyStimulus(rop, ra, rb, RW'(i), 1'($urandom_range(0, 1)), rr, rnvz);
    end
    in_valid = 1'b0;
    checkOutput("b2b_accept_cycles", cycleCnt - startCycle, 32'd16);
    @(negedge clk); #1;
    checkOutput("b2b_result_count", popCnt - startPop, 32'd16);
    idle(3);
    checkOutput("final_drained", sbQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
